trap_controller: RTL
====================

// Module: trap_controller
// PURPOSE
//  Pre-trap / trap-return sequencer upstream of the Control Unit; produces its trap_done input.
//  On an exception it saves mepc, mcause and (optionally) mtval through a dedicated CSR write port.
//  It then reads mtvec and presents the handler address.
//  On MRET it reads mepc and presents the return address.
//  While busy it holds trap_done low, which stalls the PC.
// PARAMETERS
//  XLEN  32  data/address width
// PORTS
//  clk                    in   1     system clock
//  reset                  in   1     synchronous, active-low reset
//  trap_status            in   3     0 NONE, 1 EBREAK, 2 ECALL, 3 MISALIGNED_FETCH, 4 MISALIGNED_LOAD,
//                                    5 MISALIGNED_STORE, 6 ILLEGAL, 7 MRET
//  pc                     in   XLEN  PC of the current instruction
//  bad_addr               in   XLEN  faulting address for misaligned traps
//  csr_read_data          in   XLEN  combinational CSR file read data for csr_trap_address
//  trap_done              out  1     1 = no trap sequence in progress
//  csr_trap_write         out  1     CSR write strobe
//  csr_trap_address       out  12    CSR address for read/write
//  csr_trap_write_data    out  XLEN  CSR write data
//  trap_target            out  XLEN  next PC; valid only when state==DONE
// BEHAVIOUR
//  Reset (reset==0 at posedge), including mid-sequence:
//   - state->IDLE, csr_trap_write=0, csr_trap_address=0, csr_trap_write_data=0, trap_target=0
//   - latched pc/cause/tval cleared; no partial CSR write completes after reset
//  States: IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, RD_MTVEC, RD_MEPC, DONE.
//  IDLE:
//   - trap_status==0: stay in IDLE
//   - trap_status in 1..6: latch pc, cause, tval -> WR_MEPC
//   - trap_status==7: -> RD_MEPC
//  trap_done (combinational):
//   - 1 when (IDLE and trap_status==0) or DONE, else 0
//   - drops in the same cycle a trap is presented
//  WR_MEPC:   write=1, addr 0x341, data = latched pc with [1:0]=0 -> WR_MCAUSE
//  WR_MCAUSE: write=1, addr 0x342, data = cause -> WR_MTVAL if TRAP_MTVAL_EN is defined, else RD_MTVEC
//   - cause per code: EBREAK 3, ECALL 11, FETCH 0, LOAD 4, STORE 6, ILLEGAL 2
//   - all causes zero-extended, bit XLEN-1 = 0
//  WR_MTVAL:  write=1, addr 0x343, data = latched tval -> RD_MTVEC
//  RD_MTVEC:  write=0, addr 0x305
//   - register trap_target = {csr_read_data[XLEN-1:2],2'b00}; direct mode only, MODE ignored -> DONE
//  RD_MEPC:   write=0, addr 0x341
//   - register trap_target = {csr_read_data[XLEN-1:2],2'b00} -> DONE
//  DONE:
//   - trap_done=1, trap_target held; exactly one cycle -> IDLE unconditionally
//   - trap_status is not re-sampled in DONE, so a stale code cannot retrigger
//  Non-write states: csr_trap_write=0, csr_trap_write_data=0.
//  Inputs are ignored outside IDLE; a trap_status change mid-sequence has no effect.
//  Latency, counted from IDLE detect cycle to DONE, inclusive of DONE:
//   - exception: 5 cycles (6 with TRAP_MTVAL_EN)
//   - MRET: 3 cycles
//  Back-to-back traps: a new trap presented in the cycle after DONE starts a fresh sequence.
//  mstatus is not modified here.
// CONFIGURATION
//  TRAP_MTVAL_EN defined:
//   - WR_MTVAL state present
//   - tval per code: EBREAK -> pc, misaligned -> bad_addr, ECALL/ILLEGAL -> 0
//  TRAP_MTVAL_EN undefined:
//   - no WR_MTVAL state, no tval latch
//   - mtval is never written by this block
// TESTING
//  1 ECALL, pc=0x100, mtvec reads 0x800:
//    - writes 0x341<-0x100, then 0x342<-11
//    - trap_done low 4 cycles, DONE with trap_target=0x800
//  2 MISALIGNED_LOAD, bad_addr=0x1003, TRAP_MTVAL_EN defined:
//    - writes 0x342<-4, then 0x343<-0x1003
//    - trap_done low 5 cycles
//  3 MRET, mepc reads 0x10E (bits[1:0]=2'b10):
//    - no writes; trap_target=0x10C in DONE
//    - trap_done low 2 cycles
//  4 Reset driven low during WR_MCAUSE:
//    - next cycle IDLE, csr_trap_write=0, trap_done=1 with trap_status=0
//    - no 0x342 write is observed
//  5 trap_status held at ECALL through DONE and the following cycle:
//    - exactly one sequence per DONE; new sequence begins the cycle after DONE
//  6 mtvec reads 0x801 (MODE=1):
//    - trap_target=0x800 (direct mode only)

Source files
------------

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//
// Pre-trap / trap-return sequencer that sits upstream of the Control Unit and
// produces its trap_done input.
//
// On an exception (EBREAK, ECALL, misaligned fetch/load/store, illegal), it
// writes mepc and mcause through a dedicated CSR write port. When
// TRAP_MTVAL_EN is defined it also writes mtval. It then reads mtvec and
// presents the handler address. On MRET it reads mepc and presents the return
// address. trap_done is held low while a sequence runs, which stalls the PC.
//
// Build option:
//   TRAP_MTVAL_EN  - when defined, adds the WR_MTVAL state and the tval latch.
//                    When undefined, mtval is never written by this block.
//
// Parameters:
//   XLEN                 data/address width (default 32)
//
// Ports:
//   clk                  in   1     system clock
//   reset                in   1     synchronous, active-low reset
//   trap_status          in   3     0 NONE, 1 EBREAK, 2 ECALL, 3 MISALIGNED_FETCH,
//                                   4 MISALIGNED_LOAD, 5 MISALIGNED_STORE,
//                                   6 ILLEGAL, 7 MRET
//   pc                   in   XLEN  PC of the current instruction
//   bad_addr             in   XLEN  faulting address for misaligned traps
//   csr_read_data        in   XLEN  combinational CSR read data for csr_trap_address
//   trap_done            out  1     1 = no trap sequence in progress
//   csr_trap_write       out  1     CSR write strobe
//   csr_trap_address     out  12    CSR address for read/write
//   csr_trap_write_data  out  XLEN  CSR write data
//   trap_target          out  XLEN  next PC; valid only in DONE
// -----------------------------------------------------------------------------
module trap_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] bad_addr,
    input  logic [XLEN-1:0] csr_read_data,
    output logic            trap_done,
    output logic            csr_trap_write,
    output logic [11:0]     csr_trap_address,
    output logic [XLEN-1:0] csr_trap_write_data,
    output logic [XLEN-1:0] trap_target
);

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

    localparam logic [2:0] TS_NONE = 3'd0;
    localparam logic [2:0] TS_MRET = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MEPC   = 3'd1,
        WR_MCAUSE = 3'd2,
`ifdef TRAP_MTVAL_EN
        WR_MTVAL  = 3'd3,
`endif
        RD_MTVEC  = 3'd4,
        RD_MEPC   = 3'd5,
        DONE      = 3'd6
    } state_t;

    // mcause encoding for each trap code; interrupt bit (XLEN-1) always 0.
    function automatic logic [XLEN-1:0] cause_of(input logic [2:0] code);
        logic [3:0] c;
        case (code)
            3'd1:    c = 4'd3;   // EBREAK
            3'd2:    c = 4'd11;  // ECALL
            3'd3:    c = 4'd0;   // misaligned fetch
            3'd4:    c = 4'd4;   // misaligned load
            3'd5:    c = 4'd6;   // misaligned store
            3'd6:    c = 4'd2;   // illegal instruction
            default: c = 4'd0;
        endcase
        return {{(XLEN-4){1'b0}}, c};
    endfunction

`ifdef TRAP_MTVAL_EN
    // mtval source for each trap code.
    function automatic logic [XLEN-1:0] tval_of(input logic [2:0]      code,
                                                 input logic [XLEN-1:0] pc_v,
                                                 input logic [XLEN-1:0] bad_v);
        logic [XLEN-1:0] t;
        case (code)
            3'd1:    t = pc_v;
            3'd3:    t = bad_v;
            3'd4:    t = bad_v;
            3'd5:    t = bad_v;
            default: t = {XLEN{1'b0}};
        endcase
        return t;
    endfunction
`endif

    state_t          state_r;
    state_t          state_next_s;
    logic [XLEN-1:0] cause_r;
`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] tval_r;
`endif
    logic            write_r;
    logic            write_next_s;
    logic [11:0]     addr_r;
    logic [11:0]     addr_next_s;
    // The write-data register also serves as the captured pc for WR_MEPC.
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] wdata_next_s;
    logic [XLEN-1:0] target_r;
    logic [XLEN-1:0] target_next_s;
    logic            is_exc_s;

    // Only the aligned part of the read data forms a target; mode bits are dropped.
`ifdef TRAP_MTVAL_EN
    logic unused_s;
    assign unused_s = ^csr_read_data[1:0];
`else
    logic unused_s;
    assign unused_s = ^{csr_read_data[1:0], bad_addr};
`endif

    assign is_exc_s = (trap_status != TS_NONE) && (trap_status != TS_MRET);

    // trap_done drops in the very cycle a trap is presented.
    assign trap_done = ((state_r == IDLE) && (trap_status == TS_NONE)) || (state_r == DONE);

    // The strobe is gated by reset so no write escapes while reset is asserted.
    assign csr_trap_write      = write_r & reset;
    assign csr_trap_address    = addr_r;
    assign csr_trap_write_data = wdata_r;
    assign trap_target         = target_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (trap_status == TS_MRET) begin
                    state_next_s = RD_MEPC;
                end else if (is_exc_s) begin
                    state_next_s = WR_MEPC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_MEPC:   state_next_s = WR_MCAUSE;
`ifdef TRAP_MTVAL_EN
            WR_MCAUSE: state_next_s = WR_MTVAL;
            WR_MTVAL:  state_next_s = RD_MTVEC;
`else
            WR_MCAUSE: state_next_s = RD_MTVEC;
`endif
            RD_MTVEC:  state_next_s = DONE;
            RD_MEPC:   state_next_s = DONE;
            DONE:      state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
    end

    // Output values for the coming state, so CSR port outputs come from flops.
    always_comb begin
        write_next_s  = 1'b0;
        addr_next_s   = 12'h000;
        wdata_next_s  = {XLEN{1'b0}};
        target_next_s = target_r;
        case (state_next_s)
            WR_MEPC: begin
                write_next_s = 1'b1;
                addr_next_s  = CSR_MEPC;
                wdata_next_s = {pc[XLEN-1:2], 2'b00};
            end
            WR_MCAUSE: begin
                write_next_s = 1'b1;
                addr_next_s  = CSR_MCAUSE;
                wdata_next_s = cause_r;
            end
`ifdef TRAP_MTVAL_EN
            WR_MTVAL: begin
                write_next_s = 1'b1;
                addr_next_s  = CSR_MTVAL;
                wdata_next_s = tval_r;
            end
`endif
            RD_MTVEC: begin
                addr_next_s = CSR_MTVEC;
            end
            RD_MEPC: begin
                addr_next_s = CSR_MEPC;
            end
            default: begin
                addr_next_s = 12'h000;
            end
        endcase
        // The target is captured from the read performed in the current state.
        if ((state_r == RD_MTVEC) || (state_r == RD_MEPC)) begin
            target_next_s = {csr_read_data[XLEN-1:2], 2'b00};
        end else begin
            target_next_s = target_r;
        end
    end

    // CSR port and target registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_r  <= 1'b0;
            addr_r   <= 12'h000;
            wdata_r  <= {XLEN{1'b0}};
            target_r <= {XLEN{1'b0}};
        end else begin
            write_r  <= write_next_s;
            addr_r   <= addr_next_s;
            wdata_r  <= wdata_next_s;
            target_r <= target_next_s;
        end
    end

    // Trap information latched at detection; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cause_r <= {XLEN{1'b0}};
`ifdef TRAP_MTVAL_EN
            tval_r  <= {XLEN{1'b0}};
`endif
        end else if ((state_r == IDLE) && is_exc_s) begin
            cause_r <= cause_of(trap_status);
`ifdef TRAP_MTVAL_EN
            tval_r  <= tval_of(trap_status, pc, bad_addr);
`endif
        end else begin
            cause_r <= cause_r;
`ifdef TRAP_MTVAL_EN
            tval_r  <= tval_r;
`endif
        end
    end

endmodule
